// File: rtl/sumador_param.sv
// Two-stage pipelined adder/subtractor with internal accumulator,
// wrap-around or saturating results, and per-operation/sticky overflow flags.
module sumador_param #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             valid_in,
  input  logic [1:0]       mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             valid_out,
  output logic             ovf,
  output logic             ovf_sticky
);

  localparam int unsigned RW = WIDTH + 1;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [1:0]       s1_mode;
  logic             s1_sat;
  logic             s1_valid;
  logic [WIDTH-1:0] acc;

  logic [RW-1:0]    res_wide;
  logic [WIDTH-1:0] res;
  logic             res_ovf;

  // Stage-2 arithmetic on the captured operands and the current accumulator.
  always_comb begin
    res_wide = '0;
    res_ovf  = 1'b0;
    case (s1_mode)
      MODE_ADD: begin
        res_wide = RW'(s1_a) + RW'(s1_b);
        res_ovf  = res_wide[WIDTH];
      end
      MODE_SUB: begin
        res_wide = RW'(s1_a) - RW'(s1_b);
        res_ovf  = (s1_a < s1_b);
      end
      MODE_ACC: begin
        res_wide = RW'(acc) + RW'(s1_a);
        res_ovf  = res_wide[WIDTH];
      end
      default: begin
        res_wide = '0;
        res_ovf  = 1'b0;
      end
    endcase

    res = res_wide[WIDTH-1:0];
    // Saturation clamps toward the side the overflow escaped from.
    if (s1_sat && res_ovf) begin
      res = (s1_mode == MODE_SUB) ? '0 : '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_a       <= '0;
      s1_b       <= '0;
      s1_mode    <= MODE_ADD;
      s1_sat     <= 1'b0;
      s1_valid   <= 1'b0;
      acc        <= '0;
      c          <= '0;
      valid_out  <= 1'b0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (enb) begin
      s1_a     <= a;
      s1_b     <= b;
      s1_mode  <= mode;
      s1_sat   <= sat;
      s1_valid <= valid_in;

      if (s1_valid) begin
        valid_out <= 1'b1;
        c         <= res;
        ovf       <= res_ovf;
        if (s1_mode == MODE_CLR) begin
          acc        <= '0;
          ovf_sticky <= 1'b0;
        end else begin
          ovf_sticky <= ovf_sticky | res_ovf;
          if (s1_mode == MODE_ACC) begin
            acc <= res;
          end
        end
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sumador_param.sv
// Directed-vector bench for sumador_param (WIDTH=4): reset, pipelined
// add/sub/accumulate tables, stalls and bubbles against hand-computed results.
module tb_sumador_param;

  logic       clk;
  logic       rst;
  logic       enb;
  logic       valid_in;
  logic [1:0] mode;
  logic       sat;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic       valid_out;
  logic       ovf;
  logic       ovf_sticky;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] m;
    logic       s;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic       o;
    logic       st;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  sumador_param #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .valid_in  (valid_in),
    .mode      (mode),
    .sat       (sat),
    .a         (a),
    .b         (b),
    .c         (c),
    .valid_out (valid_out),
    .ovf       (ovf),
    .ovf_sticky(ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic s,
                       input logic [3:0] av, input logic [3:0] bv);
    valid_in = v;
    mode     = m;
    sat      = s;
    a        = av;
    b        = bv;
  endtask

  task automatic check_out(input string tag, input logic [3:0] ec, input logic eo,
                           input logic est, input logic ev);
    check({tag, " c"},          32'(c),          32'(ec));
    check({tag, " ovf"},        32'(ovf),        32'(eo));
    check({tag, " ovf_sticky"}, 32'(ovf_sticky), 32'(est));
    check({tag, " valid_out"},  32'(valid_out),  32'(ev));
  endtask

  initial begin
    //            mode  sat   a      b      c      ovf   sticky
    tbl[0]  = '{2'd0, 1'b0, 4'd3,  4'd4,  4'd7,  1'b0, 1'b0};
    tbl[1]  = '{2'd1, 1'b0, 4'd9,  4'd2,  4'd7,  1'b0, 1'b0};
    tbl[2]  = '{2'd1, 1'b0, 4'd2,  4'd5,  4'd13, 1'b1, 1'b1};
    tbl[3]  = '{2'd0, 1'b1, 4'd12, 4'd9,  4'd15, 1'b1, 1'b1};
    tbl[4]  = '{2'd1, 1'b1, 4'd1,  4'd6,  4'd0,  1'b1, 1'b1};
    tbl[5]  = '{2'd0, 1'b1, 4'd15, 4'd0,  4'd15, 1'b0, 1'b1};
    tbl[6]  = '{2'd0, 1'b0, 4'd15, 4'd1,  4'd0,  1'b1, 1'b1};
    tbl[7]  = '{2'd1, 1'b0, 4'd0,  4'd1,  4'd15, 1'b1, 1'b1};
    tbl[8]  = '{2'd0, 1'b1, 4'd15, 4'd1,  4'd15, 1'b1, 1'b1};
    tbl[9]  = '{2'd1, 1'b1, 4'd0,  4'd1,  4'd0,  1'b1, 1'b1};
    tbl[10] = '{2'd3, 1'b0, 4'd9,  4'd9,  4'd0,  1'b0, 1'b0};
    tbl[11] = '{2'd2, 1'b0, 4'd5,  4'd9,  4'd5,  1'b0, 1'b0};
    tbl[12] = '{2'd2, 1'b0, 4'd6,  4'd9,  4'd11, 1'b0, 1'b0};
    tbl[13] = '{2'd2, 1'b0, 4'd7,  4'd9,  4'd2,  1'b1, 1'b1};
    tbl[14] = '{2'd3, 1'b1, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
    tbl[15] = '{2'd2, 1'b1, 4'd5,  4'd0,  4'd5,  1'b0, 1'b0};
    tbl[16] = '{2'd2, 1'b1, 4'd6,  4'd0,  4'd11, 1'b0, 1'b0};
    tbl[17] = '{2'd2, 1'b1, 4'd7,  4'd0,  4'd15, 1'b1, 1'b1};
    tbl[18] = '{2'd2, 1'b0, 4'd0,  4'd3,  4'd15, 1'b0, 1'b1};
    tbl[19] = '{2'd3, 1'b0, 4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
    tbl[20] = '{2'd0, 1'b0, 4'd3,  4'd3,  4'd6,  1'b0, 1'b0};
    tbl[21] = '{2'd2, 1'b0, 4'd1,  4'd0,  4'd1,  1'b0, 1'b0};

    rst = 1'b0;
    enb = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 4'd0, 4'd0);
    tick();
    tick();
    check_out("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Operation in flight is discarded by an asynchronous reset pulse.
    drive(1'b1, 2'd0, 1'b0, 4'd3, 4'd4);
    tick();
    drive(1'b0, 2'd0, 1'b0, 4'd0, 4'd0);
    #1 rst = 1'b0;
    #1;
    check("midrst c", 32'(c), 32'd0);
    check("midrst valid_out", 32'(valid_out), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("midrst after%0d valid_out", i), 32'(valid_out), 32'd0);
    end

    // Back-to-back table: result of row i-1 is checked after row i is captured.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) drive(1'b1, tbl[i].m, tbl[i].s, tbl[i].a, tbl[i].b);
      else        drive(1'b0, 2'd0, 1'b0, 4'd0, 4'd0);
      tick();
      if (i > 0)
        check_out($sformatf("row%0d", i - 1), tbl[i-1].c, tbl[i-1].o, tbl[i-1].st, 1'b1);
    end
    tick();
    check_out("idle", 4'd1, 1'b0, 1'b0, 1'b0);

    // Stall of three cycles right after capture delays the result by three.
    drive(1'b1, 2'd0, 1'b0, 4'd1, 4'd1);
    tick();
    drive(1'b0, 2'd0, 1'b0, 4'd0, 4'd0);
    enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("stall%0d", i), 4'd1, 1'b0, 1'b0, 1'b0);
    end
    enb = 1'b1;
    tick();
    check_out("stall result", 4'd2, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("stall after", 4'd2, 1'b0, 1'b0, 1'b0);

    // valid_out held high across a stall that begins while it is high.
    drive(1'b1, 2'd0, 1'b0, 4'd2, 4'd3);
    tick();
    drive(1'b0, 2'd0, 1'b0, 4'd0, 4'd0);
    tick();
    check_out("hold result", 4'd5, 1'b0, 1'b0, 1'b1);
    enb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_out($sformatf("hold stall%0d", i), 4'd5, 1'b0, 1'b0, 1'b1);
    end
    enb = 1'b1;
    tick();
    check_out("hold release", 4'd5, 1'b0, 1'b0, 1'b0);

    // Bubbles: invalid slots carry a clear opcode that must be ignored.
    for (int i = 0; i < 8; i++) begin
      if (i < 6 && (i % 2) == 0) drive(1'b1, 2'd0, 1'b0, 4'd8, 4'd8);
      else                       drive(1'b0, 2'd3, 1'b0, 4'd8, 4'd8);
      tick();
      if (i >= 1)
        check_out($sformatf("bubble%0d", i), 4'd0, 1'b1, 1'b1,
                  ((i - 1) < 6 && ((i - 1) % 2) == 0) ? 1'b1 : 1'b0);
    end

    // Accumulator untouched by adds and by ignored clears: acc+0 shows it.
    drive(1'b1, 2'd2, 1'b0, 4'd0, 4'd7);
    tick();
    drive(1'b0, 2'd0, 1'b0, 4'd0, 4'd0);
    tick();
    check_out("acc kept", 4'd1, 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sumador_param.md
# sumador_param

Parametrised successor of the 4-bit `sumador`: a two-stage pipelined adder/subtractor with an internal accumulator. It supports wrap-around or saturating arithmetic and per-operation and sticky overflow flags. A `valid_in`/`valid_out` qualifier travels with each operation, and `enb` freezes the whole pipeline. It sits where the original `sumador` sits and is driven by the same style of tester/testbench pair.

## Interface
- `WIDTH`, default 4: operand, accumulator and result width in bits. Legal range is ≥2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-low; clears all state while low.
- `enb` input 1: pipeline enable; when low every register holds its value.
- `valid_in` input 1: stage-1 capture qualifier for `a`, `b`, `mode`, `sat`.
- `mode` input 2: operation select.
  - 00: a+b
  - 01: a−b
  - 10: acc+a (accumulate)
  - 11: clear accumulator
- `sat` input 1: 1 = saturating result, 0 = wrap-around (modulo 2^WIDTH).
- `a` input WIDTH: operand A, unsigned.
- `b` input WIDTH: operand B, unsigned. Ignored in modes 10 and 11.
- `c` output WIDTH: registered result.
- `valid_out` output 1: `c`/`ovf` belong to an operation completed this cycle.
- `ovf` output 1: carry (add/accumulate) or borrow (sub) of the operation in `c`.
- `ovf_sticky` output 1: set by any `ovf`; cleared only by mode 11 or reset.

## Operation
- Stage 1 (S1): on a rising edge with `enb`=1:
  - Captures `a`, `b`, `mode`, `sat` into S1 registers.
  - Captures `valid_in` into `s1_valid`.
  - Operands are captured even when `valid_in`=0, but are then never used.
- Stage 2 (S2): on a rising edge with `enb`=1 and `s1_valid`=1, computes with WIDTH+1-bit intermediate:
  - 00: r = a+b; `ovf` = r[WIDTH].
  - 01: r = a−b; `ovf` = 1 iff a<b.
  - 10: r = acc+a; `ovf` = r[WIDTH]. The accumulator is loaded with the final (wrapped or saturated) result.
  - 11: acc←0, `c`←0, `ovf`←0, `ovf_sticky`←0.
- Final result:
  - `sat`=0: `c` = r[WIDTH-1:0].
  - `sat`=1 with overflow on add/accumulate: `c` = all ones.
  - `sat`=1 with borrow on sub: `c` = 0.
- Modes 00/01 never modify the accumulator.
- `ovf_sticky` ← `ovf_sticky` | `ovf` on every valid S2 completion, except mode 11, which clears it.
- On a rising edge with `enb`=1 and `s1_valid`=0:
  - `valid_out`←0.
  - `c`, `ovf`, accumulator and `ovf_sticky` hold.
- `enb`=0: S1, S2, accumulator and all outputs hold, including `valid_out`. Operations in flight are neither lost nor duplicated.
- The accumulator is read and written only in S2, so back-to-back accumulates chain correctly with no forwarding hazard.

## Timing
- Reset (`rst`=0, asynchronous): `c`=0, `valid_out`=0, `ovf`=0, `ovf_sticky`=0, accumulator=0, `s1_valid`=0.
  - Operations in flight are discarded.
  - After `rst` rises, the first capture occurs on the next enabled edge.
- Latency: an operation presented at edge N (`enb`=1) appears on `c`/`valid_out`/`ovf` after edge N+1, i.e. 2 enabled edges.
- Throughput: 1 operation per enabled cycle.
- Stall: each low-`enb` cycle delays the result by exactly one cycle.
- `valid_out` is high for exactly one enabled cycle per operation. It stays high across a stall if it was high when `enb` fell.
- Wrap boundary (WIDTH=4):
  - 15+1 → `c`=0, `ovf`=1.
  - 0−1 → `c`=15, `ovf`=1.
- Saturation boundary (WIDTH=4):
  - 15+1 → `c`=15, `ovf`=1.
  - 0−1 → `c`=0, `ovf`=1.
  - Exact 15+0 → `c`=15, `ovf`=0.

## Test plan
- Reset mid-pipeline:
  - Stimulus: 3+4 presented, then `rst` pulsed low between edges before the result appears.
  - Required: `c`=0, `valid_out`=0 immediately; no result ever emerges for that operation.
- Back-to-back add/sub (WIDTH=4, `sat`=0, `enb`=1):
  - Stimulus: 3+4, 9−2, 2−5 on consecutive edges.
  - Required: `c`=7, 7, 13 on consecutive cycles; `ovf`=0, 0, 1; `ovf_sticky`=1 afterwards.
- Saturation:
  - Stimulus: `sat`=1 with 12+9, then 1−6.
  - Required: `c`=15 with `ovf`=1, then `c`=0 with `ovf`=1.
- Accumulate chain:
  - Stimulus: mode 11, then mode 10 with a=5,6,7 consecutively.
  - Required with `sat`=0: `c`=0, then 5, 11, 2 (wrap, `ovf`=1).
  - Required with `sat`=1: the last result is 15.
- Stall:
  - Stimulus: 1+1, then `enb` low for 3 cycles right after capture.
  - Required: `c`=2 appears exactly 3 cycles later than unstalled; `valid_out` high for exactly one enabled cycle.
- Bubbles:
  - Stimulus: `valid_in` alternating 1/0 with 8+8 (`sat`=0).
  - Required: `valid_out` alternates; `c`=0, `ovf`=1 held through bubble cycles; accumulator unchanged.
